// File: rtl/irr_pkg.sv
// irr_pkg: shared types and constants for the irrigation zone scheduler.
package irr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      OPEN,
      WATER,
      CLOSE,
      FAULT
   } irr_state_t;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'b00,
      ERR_LOW_WATER = 2'b01,
      ERR_PRESSURE  = 2'b10,
      ERR_BAD_REQ   = 2'b11
   } irr_err_t;

   localparam logic [1:0] VALVE_A = 2'b01;
   localparam logic [1:0] VALVE_B = 2'b10;

endpackage

// File: rtl/irr_rr_arbiter.sv
// irr_rr_arbiter: combinational round-robin pick. Searches the pending
// vector starting at the zone after ptr_i, wrapping modulo N_ZONES.
module irr_rr_arbiter #(
   parameter int N_ZONES = 4,
   parameter int ZW      = $clog2(N_ZONES)
) (
   input  logic [N_ZONES-1:0] pending_i,
   input  logic [ZW-1:0]      ptr_i,
   output logic [ZW-1:0]      grant_o,
   output logic               any_o
);

   // first pending zone after the pointer wins
   always_comb begin
      logic [ZW-1:0] idx_v;
      grant_o = '0;
      any_o   = 1'b0;
      idx_v   = '0;
      for (int i = 1; i <= N_ZONES; i++) begin
         idx_v = ZW'((int'(ptr_i) + i) % N_ZONES);
         if (!any_o && pending_i[idx_v]) begin
            any_o   = 1'b1;
            grant_o = idx_v;
         end
      end
   end

endmodule

// File: rtl/irr_zone_sched.sv
// irr_zone_sched: round-robin multi-zone irrigation sequencer with
// water-level and line-pressure supervision and a latched fault.
// Optional build macro IRR_STRICT_REQ_EN: rejects dual-valve runs longer
// than half the run_time range with error code BAD_REQ.
//
// state | meaning
// IDLE  | waiting for a pending zone
// OPEN  | valves open, line settling, press_fault ignored
// WATER | timed watering run
// CLOSE | valves off, done pulse, zone retired, pointer advanced
// FAULT | latched error, valves off, waits for a valid err_clear
module irr_zone_sched
   import irr_pkg::*;
#(
   parameter int N_ZONES    = 4,
   parameter int RUN_W      = 8,
   parameter int SETTLE_CYC = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [2*N_ZONES-1:0]       req,
   input  logic [RUN_W-1:0]           run_time,
   input  logic                       tank_ok,
   input  logic                       press_fault,
   input  logic                       err_clear,
   output logic [2*N_ZONES-1:0]       valve_out,
   output logic [$clog2(N_ZONES)-1:0] active_zone,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [1:0]                 err_code
);

   localparam int ZW = $clog2(N_ZONES);
   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int CW = (RUN_W > SW) ? RUN_W : SW;

   irr_state_t           state_q;
   irr_err_t             code_q;
   logic [N_ZONES-1:0]   pending_q, pending_d;
   logic [2*N_ZONES-1:0] mask_q, mask_d;
   logic [2*N_ZONES-1:0] valve_q, open_vec;
   logic [N_ZONES-1:0]   clr_vec;
   logic [ZW-1:0]        rr_q, zone_q, grant;
   logic [RUN_W-1:0]     run_q;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q, done_q, err_q, any_pend;
   logic [1:0]           sel_mask;

   irr_rr_arbiter #(
      .N_ZONES (N_ZONES),
      .ZW      (ZW)
   ) u_arb (
      .pending_i (pending_q),
      .ptr_i     (rr_q),
      .grant_o   (grant),
      .any_o     (any_pend)
   );

   assign sel_mask = mask_q[{grant, 1'b0} +: 2];

`ifdef IRR_STRICT_REQ_EN
   localparam logic [RUN_W-1:0] HALF_RUN = {1'b1, {(RUN_W-1){1'b0}}};
   logic reject;
   assign reject = (sel_mask == (VALVE_A | VALVE_B)) && (run_time > HALF_RUN);
`endif

   // zones retired this cycle: the finished zone, or a rejected request
   always_comb begin
      clr_vec = '0;
      if (state_q == CLOSE) clr_vec[zone_q] = 1'b1;
`ifdef IRR_STRICT_REQ_EN
      if (state_q == IDLE && any_pend && tank_ok && reject) clr_vec[grant] = 1'b1;
`endif
   end

   // sticky request capture; a same-cycle request beats the retire clear
   always_comb begin
      pending_d = pending_q;
      mask_d    = mask_q;
      for (int z = 0; z < N_ZONES; z++) begin
         if (clr_vec[z]) begin
            pending_d[z]     = 1'b0;
            mask_d[2*z +: 2] = 2'b00;
         end
         if ((req[2*z +: 2] & (VALVE_A | VALVE_B)) != 2'b00) begin
            pending_d[z]     = 1'b1;
            mask_d[2*z +: 2] = mask_d[2*z +: 2] | req[2*z +: 2];
         end
      end
   end

   // valve pattern for the granted zone only
   always_comb begin
      open_vec = '0;
      open_vec[{grant, 1'b0} +: 2] = sel_mask;
   end

   // pending/mask storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         mask_q    <= '0;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
      end
   end

   // sequencing FSM with registered Moore outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         code_q  <= ERR_NONE;
         rr_q    <= ZW'(N_ZONES - 1);
         zone_q  <= '0;
         run_q   <= '0;
         cnt_q   <= '0;
         valve_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_pend) begin
                  if (!tank_ok) begin
                     state_q <= FAULT;
                     err_q   <= 1'b1;
                     code_q  <= ERR_LOW_WATER;
                  end
`ifdef IRR_STRICT_REQ_EN
                  else if (reject) begin
                     state_q <= FAULT;
                     err_q   <= 1'b1;
                     code_q  <= ERR_BAD_REQ;
                  end
`endif
                  else begin
                     zone_q <= grant;
                     run_q  <= run_time;
                     busy_q <= 1'b1;
                     if (run_time == '0) begin
                        state_q <= CLOSE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= OPEN;
                        cnt_q   <= CW'(SETTLE_CYC);
                        valve_q <= open_vec;
                     end
                  end
               end
            end
            OPEN: begin
               if (!tank_ok) begin
                  state_q <= FAULT;
                  valve_q <= '0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  code_q  <= ERR_LOW_WATER;
               end else if (cnt_q == CW'(1)) begin
                  state_q <= WATER;
                  cnt_q   <= CW'(run_q);
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            WATER: begin
               if (press_fault || !tank_ok) begin
                  state_q <= FAULT;
                  valve_q <= '0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  code_q  <= press_fault ? ERR_PRESSURE : ERR_LOW_WATER;
               end else if (cnt_q == CW'(1)) begin
                  state_q <= CLOSE;
                  valve_q <= '0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            CLOSE: begin
               state_q <= IDLE;
               rr_q    <= zone_q;
               busy_q  <= 1'b0;
            end
            FAULT: begin
               if (err_clear && tank_ok && !press_fault) begin
                  state_q <= IDLE;
                  err_q   <= 1'b0;
                  code_q  <= ERR_NONE;
               end
            end
            default: begin
               state_q <= IDLE;
               valve_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign valve_out   = valve_q;
   assign active_zone = zone_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign err_code    = code_q;

endmodule

// File: tb/tb_irr_zone_sched.sv
// tb_irr_zone_sched: directed self-checking bench for irr_zone_sched
// (N_ZONES=4, RUN_W=8, SETTLE_CYC=2). Build with IRR_STRICT_REQ_EN defined
// to exercise the dual-valve rejection path.
module tb_irr_zone_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] req;
   logic [7:0] run_time;
   logic       tank_ok, press_fault, err_clear;
   logic [7:0] valve_out;
   logic [1:0] active_zone;
   logic       busy, done, err;
   logic [1:0] err_code;

   int n_vec = 0;
   int n_bad = 0;

   irr_zone_sched #(
      .N_ZONES    (4),
      .RUN_W      (8),
      .SETTLE_CYC (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .run_time    (run_time),
      .tank_ok     (tank_ok),
      .press_fault (press_fault),
      .err_clear   (err_clear),
      .valve_out   (valve_out),
      .active_zone (active_zone),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .err_code    (err_code)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset       = 1'b1;
      req         = '0;
      run_time    = '0;
      tank_ok     = 1'b1;
      press_fault = 1'b0;
      err_clear   = 1'b0;
      tick;
      tick;
      reset = 1'b0;
   endtask

   // waits (bounded) for valves to open, then measures the on-time
   task automatic serve(output int zone, output logic [7:0] vals,
                        output int ontime, output logic done_seen, output logic ok);
      ok = 1'b0; zone = 0; vals = '0; ontime = 0; done_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (valve_out !== 8'h00) begin
            ok = 1'b1;
            break;
         end
         tick;
      end
      if (ok) begin
         zone = int'(active_zone);
         vals = valve_out;
         while (valve_out === vals && ontime < 300) begin
            ontime++;
            tick;
         end
         done_seen = done;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; req = '0; run_time = '0; tank_ok = 1'b1;
      press_fault = 1'b0; err_clear = 1'b0;
      tick;
      n_vec++;
      if ({valve_out, active_zone, busy, done, err, err_code} !== 15'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h required 0", {valve_out, active_zone, busy, done, err, err_code});
      end
      reset = 1'b0;
      tick; tick;
      n_vec++;
      if (busy !== 1'b0 || valve_out !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_idle: busy %b valve %h required 0/00", busy, valve_out);
      end
   endtask

   task automatic test_single_run;
      int z, t; logic [7:0] v; logic d, ok, seen;
      do_reset;
      req = 8'h04; run_time = 8'd5;
      tick;
      req = '0;
      n_vec++;
      if (valve_out !== 8'h00) begin
         n_bad++;
         $display("FAIL t1_early_valve: got %h required 00", valve_out);
      end
      tick;
      n_vec++;
      if (valve_out !== 8'h04) begin
         n_bad++;
         $display("FAIL t1_first_edge: got %h required 04", valve_out);
      end
      serve(z, v, t, d, ok);
      n_vec++;
      if (!ok || z != 1 || t != 7 || d !== 1'b1) begin
         n_bad++;
         $display("FAIL t1_run: ok %b zone %0d ontime %0d done %b required 1/1/7/1", ok, z, t, d);
      end
      tick;
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL t1_done_pulse: done %b busy %b required 0/0", done, busy);
      end
      seen = 1'b0;
      repeat (10) begin
         tick;
         if (busy !== 1'b0) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL t1_pending_clear: rerun seen %b required 0", seen);
      end
   endtask

   task automatic test_round_robin;
      int ez[5] = '{0, 2, 3, 0, 3};
      logic [7:0] ev[5] = '{8'h01, 8'h10, 8'h40, 8'h01, 8'h40};
      int z, t; logic [7:0] v; logic d, ok;
      do_reset;
      req = 8'h51; run_time = 8'd3;
      tick;
      req = '0;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) begin
            tick;
            req = 8'h41;
            tick;
            req = '0;
         end
         serve(z, v, t, d, ok);
         n_vec++;
         if (!ok || z != ez[i] || v !== ev[i] || t != 5 || d !== 1'b1) begin
            n_bad++;
            $display("FAIL t2_rr[%0d]: ok %b zone %0d valves %h ontime %0d done %b required zone %0d valves %h ontime 5 done 1",
                     i, ok, z, v, t, d, ez[i], ev[i]);
         end
      end
   endtask

   task automatic test_pressure;
      int z, t; logic [7:0] v; logic d, ok;
      do_reset;
      req = 8'h04; run_time = 8'd5;
      tick;
      req = '0;
      tick;
      press_fault = 1'b1;
      tick;
      press_fault = 1'b0;
      n_vec++;
      if (err !== 1'b0 || valve_out !== 8'h04) begin
         n_bad++;
         $display("FAIL t3_open_ignore: err %b valve %h required 0/04", err, valve_out);
      end
      tick;
      tick;
      press_fault = 1'b1;
      tick;
      n_vec++;
      if (valve_out !== 8'h00 || err !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL t3_fault: valve %h err %b code %b busy %b required 00/1/10/0", valve_out, err, err_code, busy);
      end
      err_clear = 1'b1;
      tick;
      err_clear = 1'b0;
      tick;
      n_vec++;
      if (err !== 1'b1 || err_code !== 2'b10) begin
         n_bad++;
         $display("FAIL t3_clear_ignored: err %b code %b required 1/10", err, err_code);
      end
      press_fault = 1'b0;
      tick;
      err_clear = 1'b1;
      tick;
      err_clear = 1'b0;
      n_vec++;
      if (err !== 1'b0 || err_code !== 2'b00) begin
         n_bad++;
         $display("FAIL t3_clear: err %b code %b required 0/00", err, err_code);
      end
      serve(z, v, t, d, ok);
      n_vec++;
      if (!ok || z != 1 || v !== 8'h04 || t != 7 || d !== 1'b1) begin
         n_bad++;
         $display("FAIL t3_retry: ok %b zone %0d valves %h ontime %0d done %b required 1/1/04/7/1", ok, z, v, t, d);
      end
   endtask

   task automatic test_low_water;
      int z, t; logic [7:0] v; logic d, ok, seen;
      do_reset;
      tank_ok = 1'b0; run_time = 8'd2;
      req = 8'h10;
      tick;
      req = '0;
      tick;
      n_vec++;
      if (err !== 1'b1 || err_code !== 2'b01 || valve_out !== 8'h00) begin
         n_bad++;
         $display("FAIL t4_low_water: err %b code %b valve %h required 1/01/00", err, err_code, valve_out);
      end
      seen = 1'b0;
      err_clear = 1'b1;
      tick;
      err_clear = 1'b0;
      repeat (4) begin
         tick;
         if (valve_out !== 8'h00) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0 || err !== 1'b1 || err_code !== 2'b01) begin
         n_bad++;
         $display("FAIL t4_hold: valve_seen %b err %b code %b required 0/1/01", seen, err, err_code);
      end
      tank_ok = 1'b1;
      err_clear = 1'b1;
      tick;
      err_clear = 1'b0;
      serve(z, v, t, d, ok);
      n_vec++;
      if (!ok || z != 2 || v !== 8'h10 || t != 4 || d !== 1'b1) begin
         n_bad++;
         $display("FAIL t4_retry: ok %b zone %0d valves %h ontime %0d done %b required 1/2/10/4/1", ok, z, v, t, d);
      end
   endtask

   task automatic test_short_runs;
      int z, t; logic [7:0] v; logic d, ok, seen;
      do_reset;
      run_time = 8'd0;
      req = 8'hC0;
      tick;
      req = '0;
      tick;
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b1 || valve_out !== 8'h00) begin
         n_bad++;
         $display("FAIL t5_zero_done: done %b busy %b valve %h required 1/1/00", done, busy, valve_out);
      end
      seen = 1'b0;
      repeat (8) begin
         tick;
         if (valve_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL t5_zero_quiet: activity %b required 0", seen);
      end
      run_time = 8'd1;
      req = 8'h02;
      tick;
      req = '0;
      serve(z, v, t, d, ok);
      n_vec++;
      if (!ok || z != 0 || v !== 8'h02 || t != 3 || d !== 1'b1) begin
         n_bad++;
         $display("FAIL t5_run_one: ok %b zone %0d valves %h ontime %0d done %b required 1/0/02/3/1", ok, z, v, t, d);
      end
   endtask

   task automatic test_both_faults;
      do_reset;
      run_time = 8'd4;
      req = 8'h01;
      tick;
      req = '0;
      tick; tick; tick;
      press_fault = 1'b1;
      tank_ok = 1'b0;
      tick;
      n_vec++;
      if (err !== 1'b1 || err_code !== 2'b10 || valve_out !== 8'h00) begin
         n_bad++;
         $display("FAIL t_both_priority: err %b code %b valve %h required 1/10/00", err, err_code, valve_out);
      end
      press_fault = 1'b0;
      tank_ok = 1'b1;
   endtask

   task automatic test_reset_mid_run;
      logic seen;
      do_reset;
      run_time = 8'd10;
      req = 8'h11;
      tick;
      req = '0;
      repeat (4) tick;
      n_vec++;
      if (valve_out !== 8'h01 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL t6_running: valve %h busy %b required 01/1", valve_out, busy);
      end
      #2;
      reset = 1'b1;
      #1;
      n_vec++;
      if ({valve_out, active_zone, busy, done, err, err_code} !== 15'd0) begin
         n_bad++;
         $display("FAIL t6_async_reset: got %h required 0", {valve_out, active_zone, busy, done, err, err_code});
      end
      tick;
      reset = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         tick;
         if (busy !== 1'b0 || valve_out !== 8'h00) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL t6_pending_lost: activity %b required 0", seen);
      end
   endtask

   task automatic test_dual_long;
      logic seen;
      do_reset;
      run_time = 8'd200;
      req = 8'h03;
      tick;
      req = '0;
      tick;
`ifdef IRR_STRICT_REQ_EN
      n_vec++;
      if (err !== 1'b1 || err_code !== 2'b11 || valve_out !== 8'h00) begin
         n_bad++;
         $display("FAIL t6_bad_req: err %b code %b valve %h required 1/11/00", err, err_code, valve_out);
      end
      err_clear = 1'b1;
      tick;
      err_clear = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         tick;
         if (busy !== 1'b0 || err !== 1'b0) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL t6_bad_req_cleared: activity %b required 0", seen);
      end
`else
      n_vec++;
      if (err !== 1'b0 || valve_out !== 8'h03 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL t6_dual_allowed: err %b valve %h busy %b required 0/03/1", err, valve_out, busy);
      end
      seen = 1'b0;
      repeat (8) begin
         tick;
         if (err !== 1'b0 || err_code !== 2'b00) seen = 1'b1;
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL t6_no_bad_code: error seen %b required 0", seen);
      end
`endif
      do_reset;
   endtask

   initial begin
      test_reset;
      test_single_run;
      test_round_robin;
      test_pressure;
      test_low_water;
      test_short_runs;
      test_both_faults;
      test_reset_mid_run;
      test_dual_long;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/irr_zone_sched.md
Name: irr_zone_sched

Overview:
Parametrised successor to the two-zone irrigation controller. Serves N_ZONES zones, each with two valves, round-robin, one zone at a time. Each run lasts a programmable number of cycles and is guarded by water-level and pressure supervision, with a latched fault and explicit clear. Sits between the zone request inputs and the valve drivers, beside the water-level FSM that supplies tank_ok and press_fault.

Parameters:
N_ZONES, 4, number of zones (2..16).
RUN_W, 8, width of run_time.
SETTLE_CYC, 2, cycles after valve opening during which press_fault is ignored (>=1).

Ports:
clk  in  1  clock.
reset  in  1  reset.
req  in  2*N_ZONES  per-zone valve request; bits [2z+1:2z] are zone z, 01=valve A, 10=valve B, 11=both, 00=none.
run_time  in  RUN_W  run duration in cycles, sampled at zone start.
tank_ok  in  1  water available (from level FSM).
press_fault  in  1  line pressure fault.
err_clear  in  1  single-cycle fault acknowledge.
valve_out  out  2*N_ZONES  valve drive, same bit layout as req.
active_zone  out  $clog2(N_ZONES)  zone being served, valid while busy.
busy  out  1  high in OPEN/WATER/CLOSE.
done  out  1  one-cycle pulse when a zone finishes.
err  out  1  high in FAULT.
err_code  out  2  00 none, 01 LOW_WATER, 10 PRESSURE, 11 BAD_REQ.

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On reset: state=IDLE, pending=0, masks=0, rr pointer=N_ZONES-1, and all outputs 0.
- Request capture: each cycle, a zone with nonzero req sets pending[z] and ORs req bits into mask[z]. Masks are sticky until the zone is served.
- Zone selection takes 1 cycle to register. The first valve edge appears 2 cycles after the req edge.
- States: IDLE, OPEN, WATER, CLOSE, FAULT. All outputs are registered and Moore.
- IDLE:
  - !tank_ok with pending!=0 -> FAULT, code LOW_WATER.
  - Otherwise, if pending!=0, pick the first pending zone after the rr pointer (wrapping modulo N_ZONES). Capture the zone, its mask and run_time.
  - If captured run_time==0 -> CLOSE directly, valves never open.
  - Otherwise -> OPEN.
- OPEN: valve_out drives the captured mask on the captured zone only. Lasts exactly SETTLE_CYC cycles. press_fault is ignored; tank_ok low -> FAULT (LOW_WATER). Then -> WATER.
- WATER: counter loads run_time and decrements each cycle; valves stay asserted for exactly run_time cycles.
  - press_fault -> FAULT (PRESSURE).
  - !tank_ok -> FAULT (LOW_WATER).
  - If both fault in the same cycle, PRESSURE wins.
  - Counter reaching 1 -> CLOSE.
- CLOSE: 1 cycle. Valves off; done=1; pending[z] and mask[z] cleared; rr pointer=z. A new req for z in this same cycle sets pending again (set wins over clear). -> IDLE.
- FAULT:
  - All valves off within 1 cycle of entry. err=1, err_code held.
  - The aborted zone keeps its pending bit and mask and is retried after recovery.
  - Exit to IDLE only on err_clear while tank_ok=1 and press_fault=0; otherwise err_clear is ignored.
  - err_code returns to 00 on exit.
- BAD_REQ: a request with G-style both-valves on every zone simultaneously is not an error. BAD_REQ is reserved and unused unless IRR_STRICT_REQ_EN is defined.
- Requests arriving for the active zone during OPEN/WATER OR into its mask but do not change the valves until its next run.
- Reset mid-run: valves drop asynchronously; all pending requests are lost.

Optional Feature:
IRR_STRICT_REQ_EN
- Defined: in IDLE, a selected zone whose mask is 11 while run_time > (2**RUN_W)/2 is rejected. The FSM goes to FAULT, code BAD_REQ (double-valve long runs are forbidden), and that zone's pending and mask are cleared.
- Undefined: no check; code 11 is never produced.

Decomposition:
- Package irr_pkg: state enum irr_state_t {IDLE, OPEN, WATER, CLOSE, FAULT}, enum irr_err_t {ERR_NONE, ERR_LOW_WATER, ERR_PRESSURE, ERR_BAD_REQ}, valve encoding constants VALVE_A=2'b01, VALVE_B=2'b10.
- Sub-module irr_rr_arbiter: combinational round-robin pick over the pending vector given the pointer. Outputs grant index and any_valid.

Test Plan:
1. N_ZONES=4, SETTLE=2, tank_ok=1: req zone1=01 for one cycle, run_time=5 -> valve_out[3:2]=01 for exactly 7 cycles, starting 2 cycles after req; done pulse; pending clears.
2. Zones 0, 2, 3 requested together, run_time=3 -> served in order 0, 2, 3, each with done; rr pointer ends at 3; next req zone0 is then served first.
3. press_fault during cycle 1 of OPEN -> ignored. press_fault during WATER cycle 2 -> valves 0 the next cycle, err=1, code 10; err_clear with press_fault still 1 -> stays in FAULT; clear after it drops -> IDLE, then the same zone reruns in full.
4. tank_ok=0 with pending zone2 -> FAULT, code 01, no valve ever asserted.
5. run_time=0 with zone3 requested -> done pulse, valves never asserted, pending[3]=0.
6. Assert reset during WATER -> all outputs 0 immediately, pending=0. With IRR_STRICT_REQ_EN: mask 11, run_time=200 -> FAULT, code 11.
